// File: rtl/dlx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dlx_pkg                                                          |
// | Shared DLX decode constants: opcodes, field widths, offset types |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package dlx_pkg;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 6;
  localparam int IMM16_W  = 16;
  localparam int OFF26_W  = 26;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_J    = 6'h02;
  localparam opcode_t OP_JAL  = 6'h03;
  localparam opcode_t OP_BEQZ = 6'h04;
  localparam opcode_t OP_BNEZ = 6'h05;
  localparam opcode_t OP_BFPT = 6'h06;
  localparam opcode_t OP_BFPF = 6'h07;
  localparam opcode_t OP_RFE  = 6'h10;
  localparam opcode_t OP_TRAP = 6'h11;
  localparam opcode_t OP_JR   = 6'h12;
  localparam opcode_t OP_JALR = 6'h13;

  typedef enum logic {
    OFF_IMM16 = 1'b0,
    OFF_OFF26 = 1'b1
  } off_sel_e;

  function automatic logic [XLEN-1:0] sext16(input logic [IMM16_W-1:0] v);
    return {{(XLEN-IMM16_W){v[IMM16_W-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext26(input logic [OFF26_W-1:0] v);
    return {{(XLEN-OFF26_W){v[OFF26_W-1]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/jump_branch_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jump_branch_unit_if                                              |
// | Decode-stage bundle between control decoder and transfer resolver|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface jump_branch_unit_if;
  import dlx_pkg::*;

  // Instruction uses big-endian bit numbering: opcode is [0:5].
  logic [0:XLEN-1] instruction;
  logic [XLEN-1:0] pc_plus_four;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] outputPC;
  logic            takeBranch;
  logic [XLEN-1:0] register31;

  modport master (
    output instruction, pc_plus_four, rs1,
    input  outputPC, takeBranch, register31
  );

  modport slave (
    input  instruction, pc_plus_four, rs1,
    output outputPC, takeBranch, register31
  );

endinterface
`default_nettype wire

// File: rtl/jump_branch_unit_branch_target_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_target_adder                                              |
// | pc_plus_four + sign-extended imm16 or off26, modulo 2^32         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module branch_target_adder
  import dlx_pkg::*;
(
  input  wire logic [XLEN-1:0]    pc_plus_four,
  input  wire logic [IMM16_W-1:0] imm16,
  input  wire logic [OFF26_W-1:0] off26,
  input  wire off_sel_e           off_sel,
  output logic      [XLEN-1:0]    target
);

  logic [XLEN-1:0] w_offset;

  assign w_offset = (off_sel == OFF_OFF26) ? sext26(off26) : sext16(imm16);
  // Carry out is discarded on purpose: wrap-around is architectural.
  assign target   = pc_plus_four + w_offset;

endmodule
`default_nettype wire

// File: rtl/jump_branch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jump_branch_unit                                                 |
// | Combinational jump/branch resolve plus registered r31 link value |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module jump_branch_unit
  import dlx_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         reset,
  jump_branch_unit_if.slave jb
);

  opcode_t              w_opcode;
  logic [IMM16_W-1:0]   w_imm16;
  logic [OFF26_W-1:0]   w_off26;
  off_sel_e             w_off_sel;
  logic                 w_take;
  logic                 w_use_rs1;
  logic                 w_link;
  logic [XLEN-1:0]      w_target;
  logic [XLEN-1:0]      r_reg31;

  assign w_opcode = jb.instruction[0:OPCODE_W-1];
  assign w_imm16  = jb.instruction[XLEN-IMM16_W:XLEN-1];
  assign w_off26  = jb.instruction[XLEN-OFF26_W:XLEN-1];

  branch_target_adder u_adder (
    .pc_plus_four (jb.pc_plus_four),
    .imm16        (w_imm16),
    .off26        (w_off26),
    .off_sel      (w_off_sel),
    .target       (w_target)
  );

  // Default arm is not-taken so an unknown opcode never forces a transfer.
  always_comb begin
    w_take    = 1'b0;
    w_use_rs1 = 1'b0;
    w_off_sel = OFF_IMM16;
    w_link    = 1'b0;
    case (w_opcode)
      OP_J: begin
        w_take    = 1'b1;
        w_off_sel = OFF_OFF26;
      end
      OP_JAL: begin
        w_take    = 1'b1;
        w_off_sel = OFF_OFF26;
        w_link    = 1'b1;
      end
      OP_BEQZ: w_take = (jb.rs1 == '0);
      OP_BNEZ: w_take = (jb.rs1 != '0);
      OP_JR: begin
        w_take    = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OP_JALR: begin
        w_take    = 1'b1;
        w_use_rs1 = 1'b1;
        w_link    = 1'b1;
      end
      OP_BFPT, OP_BFPF, OP_RFE, OP_TRAP: w_take = 1'b0;
      default: w_take = 1'b0;
    endcase
  end

  assign jb.takeBranch = w_take;
  assign jb.outputPC   = !w_take   ? jb.pc_plus_four :
                         w_use_rs1 ? jb.rs1          : w_target;

  // Link is written one edge after JAL/JALR decode, so a JALR through r31
  // has already consumed the forwarded rs1 before the update lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg31 <= '0;
    end else if (w_link) begin
      r_reg31 <= jb.pc_plus_four;
    end
  end

  assign jb.register31 = r_reg31;

endmodule
`default_nettype wire

// File: tb/tb_jump_branch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_jump_branch_unit                                              |
// | Directed vector table plus reset/link sequences                  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_jump_branch_unit;

  logic clk;
  logic reset;

  jump_branch_unit_if jb_if();

  jump_branch_unit dut (
    .clk   (clk),
    .reset (reset),
    .jb    (jb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] rs1;
    logic        exp_take;
    logic [31:0] exp_pc;
    logic [31:0] exp_r31;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int n_cmp;
  int n_bad;

  function automatic logic [31:0] fj(input logic [5:0] op, input logic [25:0] off);
    return {op, off};
  endfunction

  function automatic logic [31:0] fb(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc4, input logic [31:0] rs);
    jb_if.instruction  = instr;
    jb_if.pc_plus_four = pc4;
    jb_if.rs1          = rs;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{"j_fwd",       fj(6'h02, 26'h0000010),  32'h0000_1000, 32'h0,          1'b1, 32'h0000_1010, 32'h0};
    vecs[1]  = '{"jal_back",    fj(6'h03, 26'h3FFFFFC),  32'h0000_2000, 32'h0,          1'b1, 32'h0000_1FFC, 32'h0000_2000};
    vecs[2]  = '{"beqz_taken",  fb(6'h04, 16'h0008),     32'h0000_3000, 32'h0,          1'b1, 32'h0000_3008, 32'h0000_2000};
    vecs[3]  = '{"beqz_not",    fb(6'h04, 16'h0008),     32'h0000_3000, 32'h5,          1'b0, 32'h0000_3000, 32'h0000_2000};
    vecs[4]  = '{"bnez_taken",  fb(6'h05, 16'h0008),     32'h0000_3000, 32'h5,          1'b1, 32'h0000_3008, 32'h0000_2000};
    vecs[5]  = '{"bnez_not",    fb(6'h05, 16'h0008),     32'h0000_3000, 32'h0,          1'b0, 32'h0000_3000, 32'h0000_2000};
    vecs[6]  = '{"jr",          fj(6'h12, 26'h0),        32'h0000_4000, 32'h0040_0000,  1'b1, 32'h0040_0000, 32'h0000_2000};
    vecs[7]  = '{"jalr",        fj(6'h13, 26'h0),        32'h0000_0080, 32'h0000_1234,  1'b1, 32'h0000_1234, 32'h0000_0080};
    vecs[8]  = '{"bnez_wrap",   fb(6'h05, 16'h0010),     32'hFFFF_FFF8, 32'h1,          1'b1, 32'h0000_0008, 32'h0000_0080};
    vecs[9]  = '{"addi",        fb(6'h08, 16'h0010),     32'h0000_0500, 32'h0,          1'b0, 32'h0000_0500, 32'h0000_0080};
    vecs[10] = '{"lw",          fb(6'h23, 16'hFFF0),     32'h0000_0504, 32'h7,          1'b0, 32'h0000_0504, 32'h0000_0080};
    vecs[11] = '{"trap",        fj(6'h11, 26'h0000040),  32'h0000_0508, 32'h0,          1'b0, 32'h0000_0508, 32'h0000_0080};
    vecs[12] = '{"bfpt",        fb(6'h06, 16'h0020),     32'h0000_050C, 32'h0,          1'b0, 32'h0000_050C, 32'h0000_0080};
    vecs[13] = '{"bfpf",        fb(6'h07, 16'h0020),     32'h0000_0510, 32'h1,          1'b0, 32'h0000_0510, 32'h0000_0080};
    vecs[14] = '{"rfe",         fj(6'h10, 26'h0),        32'h0000_0514, 32'h9,          1'b0, 32'h0000_0514, 32'h0000_0080};
    vecs[15] = '{"j_wrap",      fj(6'h02, 26'h0000008),  32'hFFFF_FFFC, 32'h0,          1'b1, 32'h0000_0004, 32'h0000_0080};
    vecs[16] = '{"beqz_neg",    fb(6'h04, 16'hFFF0),     32'h0000_0100, 32'h0,          1'b1, 32'h0000_00F0, 32'h0000_0080};
    vecs[17] = '{"jalr_odd",    fj(6'h13, 26'h0),        32'h0000_0044, 32'h0000_0003,  1'b1, 32'h0000_0003, 32'h0000_0044};

    reset = 1'b1;
    drive(32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset_r31", jb_if.register31, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].pc4, vecs[i].rs1);
      #1;
      check({vecs[i].name, "_take"}, {31'd0, jb_if.takeBranch}, {31'd0, vecs[i].exp_take});
      check({vecs[i].name, "_pc"},   jb_if.outputPC, vecs[i].exp_pc);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_r31"},  jb_if.register31, vecs[i].exp_r31);
    end

    // Load a link, then hit reset between edges.
    @(negedge clk);
    drive(fj(6'h03, 26'h0000004), 32'h0000_7777, 32'h0);
    @(posedge clk);
    #1;
    check("seq_jal_load", jb_if.register31, 32'h0000_7777);
    @(negedge clk);
    drive(fb(6'h08, 16'h0001), 32'h0000_7800, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_r31", jb_if.register31, 32'h0);

    // Decode stays live during reset while the link stays cleared.
    drive(fj(6'h03, 26'h0000010), 32'h0000_8000, 32'h0);
    #1;
    check("rst_jal_take", {31'd0, jb_if.takeBranch}, 32'h1);
    check("rst_jal_pc",   jb_if.outputPC, 32'h0000_8010);
    @(posedge clk);
    #1;
    check("rst_held_r31", jb_if.register31, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    drive(fj(6'h03, 26'h0000000), 32'h0000_9990, 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_jal_r31", jb_if.register31, 32'h0000_9990);

    // JALR via r31: target uses forwarded rs1, link lands on the next edge.
    @(negedge clk);
    drive(fj(6'h13, 26'h0), 32'h0000_AAA0, 32'h0000_9990);
    #1;
    check("jalr_r31_pc", jb_if.outputPC, 32'h0000_9990);
    check("jalr_r31_pre", jb_if.register31, 32'h0000_9990);
    @(posedge clk);
    #1;
    check("jalr_r31_post", jb_if.register31, 32'h0000_AAA0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
